// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 RISC-V integer register file with writeback select,
// write-through bypass to both read ports and a committed-write counter.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   wb_alu, wb_mem      writeback candidates from MEM/WB
//   wb_rd               destination register index
//   wb_regwrite         writeback enable
//   wb_memtoreg         1 selects wb_mem, 0 selects wb_alu
//   rs1_addr, rs2_addr  read port indices (ID stage)
//   rs1_data, rs2_data  read port data (combinational, bypassed)
//   wb_value            selected writeback value, for forwarding
//   wb_commit           a register write takes effect this cycle
//   wb_count            number of committed register writes (wraps)
module wb_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_alu,
    input  logic [31:0] wb_mem,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic        wb_memtoreg,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] wb_value,
    output logic        wb_commit,
    output logic [31:0] wb_count
);

    logic [31:0] regs [32];
    logic [31:0] count_q;

    assign wb_value  = wb_memtoreg ? wb_mem : wb_alu;
    // x0 writes never commit, so they neither store, count nor bypass.
    assign wb_commit = wb_regwrite && (wb_rd != 5'd0) && !reset;
    assign wb_count  = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            count_q <= 32'd0;
        end else if (wb_commit) begin
            regs[wb_rd] <= wb_value;
            count_q     <= count_q + 32'd1;
        end
    end

    // wb_commit already excludes rd==0, so the bypass can never leak a
    // value onto an x0 read.
    always_comb begin
        rs1_data = 32'd0;
        if (wb_commit && (rs1_addr == wb_rd)) begin
            rs1_data = wb_value;
        end else if (rs1_addr != 5'd0) begin
            rs1_data = regs[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = 32'd0;
        if (wb_commit && (rs2_addr == wb_rd)) begin
            rs2_data = wb_value;
        end else if (rs2_addr != 5'd0) begin
            rs2_data = regs[rs2_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table plus hand-written reset,
// X-input and counter-wrap sequences for wb_regfile.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] wb_alu;
    logic [31:0] wb_mem;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_value;
    logic        wb_commit;
    logic [31:0] wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .wb_alu      (wb_alu),
        .wb_mem      (wb_mem),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .wb_memtoreg (wb_memtoreg),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_value    (wb_value),
        .wb_commit   (wb_commit),
        .wb_count    (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mt;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_commit;
        logic [31:0] e_value;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mt, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] r1, input logic [4:0] r2);
        wb_regwrite = rw;
        wb_memtoreg = mt;
        wb_rd       = rd;
        wb_alu      = alu;
        wb_mem      = mem;
        rs1_addr    = r1;
        rs2_addr    = r2;
    endtask

    initial begin
        //                rw  mt  rd     alu           mem           rs1    rs2    e_rs1         e_rs2         ec    e_value       e_count
        vecs[0]  = '{1'b0,1'b0,5'd0, 32'h0,        32'h0,        5'd5,  5'd31, 32'h0,        32'h0,        1'b0, 32'h0,        32'd0};
        vecs[1]  = '{1'b1,1'b0,5'd5, 32'h12345678, 32'h0,        5'd5,  5'd6,  32'h12345678, 32'h0,        1'b1, 32'h12345678, 32'd1};
        vecs[2]  = '{1'b1,1'b1,5'd6, 32'h0,        32'hDEADBEEF, 5'd5,  5'd6,  32'h12345678, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'd2};
        vecs[3]  = '{1'b0,1'b0,5'd0, 32'h0,        32'h0,        5'd5,  5'd6,  32'h12345678, 32'hDEADBEEF, 1'b0, 32'h0,        32'd2};
        vecs[4]  = '{1'b1,1'b0,5'd0, 32'hFFFFFFFF, 32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 32'd2};
        vecs[5]  = '{1'b0,1'b0,5'd0, 32'h0,        32'h0,        5'd0,  5'd5,  32'h0,        32'h12345678, 1'b0, 32'h0,        32'd2};
        vecs[6]  = '{1'b1,1'b0,5'd7, 32'h11,       32'h0,        5'd7,  5'd7,  32'h11,       32'h11,       1'b1, 32'h11,       32'd3};
        vecs[7]  = '{1'b1,1'b0,5'd7, 32'h22,       32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       1'b1, 32'h22,       32'd4};
        vecs[8]  = '{1'b0,1'b0,5'd7, 32'h0,        32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       1'b0, 32'h0,        32'd4};
        vecs[9]  = '{1'b0,1'b1,5'd3, 32'h66,       32'h55,       5'd7,  5'd3,  32'h22,       32'h0,        1'b0, 32'h55,       32'd4};
        vecs[10] = '{1'b1,1'b0,5'd8, 32'h1,        32'h0,        5'd8,  5'd0,  32'h1,        32'h0,        1'b1, 32'h1,        32'd5};
        vecs[11] = '{1'b1,1'b0,5'd8, 32'h2,        32'h0,        5'd8,  5'd8,  32'h2,        32'h2,        1'b1, 32'h2,        32'd6};
        vecs[12] = '{1'b0,1'b0,5'd7, 32'h0,        32'h0,        5'd8,  5'd5,  32'h2,        32'h12345678, 1'b0, 32'h0,        32'd6};

        reset = 1'b1;
        drive(1'b1, 1'b0, 5'd4, 32'h99, 32'h0, 5'd4, 5'd0);
        #1;
        check("commit_in_reset", {31'd0, wb_commit}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0);
        #1;
        check("reset_x4", rs1_data, 32'h0);
        check("reset_count", wb_count, 32'd0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].rw, vecs[i].mt, vecs[i].rd, vecs[i].alu,
                  vecs[i].mem, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].e_rs1);
            check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].e_rs2);
            check($sformatf("v%0d_commit", i), {31'd0, wb_commit},
                  {31'd0, vecs[i].e_commit});
            check($sformatf("v%0d_value", i), wb_value, vecs[i].e_value);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), wb_count, vecs[i].e_count);
        end

        // Unknown data with writeback disabled must not disturb state.
        @(negedge clk);
        drive(1'b0, 1'bx, 5'bx, 32'hx, 32'hx, 5'd8, 5'd7);
        @(posedge clk);
        #1;
        check("x_count", wb_count, 32'd6);
        check("x_rs1", rs1_data, 32'h2);
        check("x_rs2", rs2_data, 32'h22);

        // Write x9, then reset while a write is still requested.
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd9, 32'hA5A5A5A5, 32'h0, 5'd9, 5'd8);
        @(posedge clk);
        #1;
        check("x9_written", rs1_data, 32'hA5A5A5A5);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 5'd9, 32'h77, 32'h0, 5'd9, 5'd8);
        #1;
        check("rst_commit", {31'd0, wb_commit}, 32'd0);
        check("rst_no_bypass", rs1_data, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        check("rst_x9", rs1_data, 32'h0);
        check("rst_x8", rs2_data, 32'h0);
        check("rst_count", wb_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("resume_commit", {31'd0, wb_commit}, 32'd1);
        @(posedge clk);
        #1;
        check("resume_count", wb_count, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd8);
        #1;
        check("resume_x9", rs1_data, 32'h77);
        check("resume_x8", rs2_data, 32'h0);

        // Counter wrap via backdoor preload.
        dut.count_q = 32'hFFFFFFFF;
        #1;
        check("wrap_pre", wb_count, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd10, 32'h3, 32'h0, 5'd10, 5'd0);
        @(posedge clk);
        #1;
        check("wrap_count", wb_count, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd10, 5'd0);
        #1;
        check("wrap_x10", rs1_data, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port wb_alu, input, 32 bits: ALU result from the MEM/WB register.
REQ-004 The block SHALL have the port wb_mem, input, 32 bits: load data from the MEM/WB register.
REQ-005 The block SHALL have the port wb_rd, input, 5 bits: destination register index.
REQ-006 The block SHALL have the port wb_regwrite, input, 1 bit: writeback enable.
REQ-007 The block SHALL have the port wb_memtoreg, input, 1 bit: 1 selects wb_mem, 0 selects wb_alu.
REQ-008 The block SHALL have the port rs1_addr, input, 5 bits: read port 1 index (ID stage).
REQ-009 The block SHALL have the port rs2_addr, input, 5 bits: read port 2 index (ID stage).
REQ-010 The block SHALL have the port rs1_data, output, 32 bits: read port 1 data.
REQ-011 The block SHALL have the port rs2_data, output, 32 bits: read port 2 data.
REQ-012 The block SHALL have the port wb_value, output, 32 bits: selected writeback value, for forwarding.
REQ-013 The block SHALL have the port wb_commit, output, 1 bit: high when a register write takes effect this cycle.
REQ-014 The block SHALL have the port wb_count, output, 32 bits: count of committed register writes.

Function
REQ-015 wb_value SHALL be combinational: wb_memtoreg ? wb_mem : wb_alu, independent of wb_regwrite.
REQ-016 wb_commit SHALL be combinational: wb_regwrite && (wb_rd != 0) && !reset.
REQ-017 Storage SHALL be 32 entries of 32 bits; entry 0 SHALL never be written and SHALL always read 0.
REQ-018 On a rising edge with wb_commit=1, entry wb_rd SHALL take wb_value; otherwise all entries SHALL hold.
REQ-019 Reads SHALL be combinational, with zero-cycle latency from rsX_addr to rsX_data.
REQ-020 Write-through bypass: if wb_commit=1 and rsX_addr==wb_rd, rsX_data SHALL equal wb_value in the same cycle.
REQ-021 Otherwise rsX_data SHALL equal the stored entry, or 0 when rsX_addr==0.
REQ-022 Both read ports SHALL be independent; rs1_addr==rs2_addr SHALL return identical data on both.
REQ-023 A write with wb_rd=0 and wb_regwrite=1 SHALL be discarded without changing wb_count, and SHALL NOT bypass.
REQ-024 wb_count SHALL increment by 1 on each rising edge where wb_commit=1; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-025 Back-to-back writes to the same rd SHALL leave the last value stored; each write SHALL be counted.
REQ-026 X/unknown inputs with wb_regwrite=0 SHALL NOT alter storage or wb_count.

Reset
REQ-027 While reset=1 at a rising edge, all 32 entries SHALL be cleared to 0 and wb_count SHALL be cleared to 0.
REQ-028 While reset=1, wb_commit SHALL be 0 and no write SHALL occur, even if wb_regwrite=1.
REQ-029 A reset asserted between back-to-back writes SHALL discard all prior state; writes resume on the first edge with reset=0.
REQ-030 After reset, rs1_data, rs2_data and wb_count SHALL read 0 until the first commit.

Verification
REQ-031 Reset, then rs1_addr=5 and rs2_addr=31 -> rs1_data=0, rs2_data=0, wb_count=0.
REQ-032 Write x5 with wb_memtoreg=0 and wb_alu=0x12345678, then x6 with wb_memtoreg=1 and wb_mem=0xDEADBEEF -> reads return 0x12345678 and 0xDEADBEEF; wb_count=2.
REQ-033 wb_regwrite=1, wb_rd=0, wb_alu=0xFFFFFFFF, rs1_addr=0 -> rs1_data=0 before and after the edge; wb_count unchanged.
REQ-034 Same-cycle bypass: x7 holds 0x11, commit x7=0x22, rs1_addr=rs2_addr=7 -> both ports read 0x22 before the edge and 0x22 after it.
REQ-035 Write x9=0xA5A5A5A5, then assert reset for one cycle while wb_regwrite=1 -> x9 reads 0, wb_count=0, wb_commit=0 during reset.
REQ-036 Force wb_count to 0xFFFFFFFF by 2^32-1 commits (or backdoor), then commit once -> wb_count=0.
